// File: rtl/alu_downcounter.sv
// Loadable down-counter/timer with terminal-count pulse, optional auto-reload
// and a sticky underflow flag for enables that arrive after expiry.
module alu_downcounter #(
  parameter int unsigned          WIDTH          = 8,
  parameter logic [WIDTH-1:0]     RELOAD_DEFAULT = 8'hFF
) (
  input  logic             clk,
  input  logic             rb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clr_uf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             underflow,
  output logic             busy
);

  // state   | meaning
  // IDLE    | out of reset, waiting for load or start; en ignored
  // RUN     | decrementing on each en
  // EXPIRED | one-shot finished, count held at 0; en flags underflow
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             uf_set;
  logic             underflow_nxt;

  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= RELOAD_DEFAULT;
      tc         <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
      underflow  <= underflow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    uf_set     = 1'b0;

    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : EXPIRED;
    end else if (start) begin
      count_nxt = reload_reg;
      state_nxt = (reload_reg != '0) ? RUN : EXPIRED;
    end else if (en) begin
      unique case (state)
        RUN: begin
          if (count > ONE) begin
            count_nxt = count - ONE;
          end else if (count == ONE) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else if (auto_reload && (reload_reg != '0)) begin
            // auto_reload only matters here, at the zero decision point
            count_nxt = reload_reg;
          end else begin
            state_nxt = EXPIRED;
          end
        end
        EXPIRED: uf_set = 1'b1;
        default: ;
      endcase
    end
  end

  // a new underflow outranks a simultaneous clear
  always_comb begin
    underflow_nxt = underflow;
    if (uf_set) begin
      underflow_nxt = 1'b1;
    end else if (clr_uf) begin
      underflow_nxt = 1'b0;
    end
  end

  assign zero = (count == '0);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_alu_downcounter.sv
// Scoreboard bench for alu_downcounter: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_alu_downcounter;

  logic       clk = 1'b0;
  logic       rb;
  logic       load, start, en, auto_reload, clr_uf;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc, zero, underflow, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       underflow;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // reference model: mode 0 = idle, 1 = running, 2 = expired
  int         m_mode;
  int         m_count;
  int         m_reload;
  logic       m_uf;

  alu_downcounter #(.WIDTH(8), .RELOAD_DEFAULT(8'hFF)) dut (
    .clk(clk), .rb(rb), .load(load), .load_val(load_val), .start(start),
    .en(en), .auto_reload(auto_reload), .clr_uf(clr_uf), .count(count),
    .tc(tc), .zero(zero), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_mode   = 0;
    m_count  = 0;
    m_reload = 255;
    m_uf     = 1'b0;
  endfunction

  task automatic step(input string tag, input logic ld, input logic [7:0] lv,
                      input logic st, input logic e, input logic ar,
                      input logic clr);
    exp_t x;
    logic tc_exp;
    logic uf_hit;
    @(negedge clk);
    load = ld; load_val = lv; start = st; en = e; auto_reload = ar; clr_uf = clr;
    tc_exp = 1'b0;
    uf_hit = 1'b0;
    if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_mode   = (lv == 0) ? 2 : 1;
    end else if (st) begin
      m_count = m_reload;
      m_mode  = (m_reload == 0) ? 2 : 1;
    end else if (e) begin
      if (m_mode == 1) begin
        if (m_count >= 2) m_count = m_count - 1;
        else if (m_count == 1) begin
          m_count = 0;
          tc_exp  = 1'b1;
        end else if (ar && m_reload != 0) m_count = m_reload;
        else m_mode = 2;
      end else if (m_mode == 2) begin
        uf_hit = 1'b1;
      end
    end
    if (uf_hit) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    x.count     = m_count[7:0];
    x.tc        = tc_exp;
    x.underflow = m_uf;
    x.busy      = (m_mode == 1);
    x.tag       = tag;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk({x.tag, ".count"}, count, x.count);
      chk({x.tag, ".tc"}, tc, x.tc);
      chk({x.tag, ".zero"}, zero, (x.count == 8'd0));
      chk({x.tag, ".underflow"}, underflow, x.underflow);
      chk({x.tag, ".busy"}, busy, x.busy);
    end
  end

  initial begin
    rb = 1'b0;
    load = 0; load_val = 0; start = 0; en = 0; auto_reload = 0; clr_uf = 0;
    model_reset();
    #12;
    chk("rst.count", count, 0);
    chk("rst.zero", zero, 1);
    chk("rst.busy", busy, 0);
    chk("rst.tc", tc, 0);
    chk("rst.underflow", underflow, 0);
    @(negedge clk);
    rb = 1'b1;

    for (int i = 0; i < 3; i++) step("idle_en", 0, 0, 0, 1, 0, 0);
    step("start_dflt", 0, 0, 1, 0, 0, 0);

    step("os_load3", 1, 8'd3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("os_en", 0, 0, 0, 1, 0, 0);
    step("os_clr", 0, 0, 0, 0, 0, 1);

    step("ar_load2", 1, 8'd2, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step("ar_en", 0, 0, 0, 1, 1, 0);

    step("z_load0", 1, 8'd0, 0, 0, 0, 0);
    step("z_start", 0, 0, 1, 0, 0, 0);
    step("z_en", 0, 0, 0, 1, 0, 0);
    step("z_clr_en", 0, 0, 0, 1, 0, 1);
    step("z_clr", 0, 0, 0, 0, 0, 1);

    step("pri_load5", 1, 8'd5, 0, 0, 0, 0);
    step("pri_all", 1, 8'd7, 1, 1, 0, 0);
    step("pri_en", 0, 0, 0, 1, 0, 0);
    step("pri_start", 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] lv;
      int sel;
      sel = $urandom_range(0, 3);
      lv = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'($urandom_range(2, 6))
                                                               : 8'($urandom);
      step("rnd", ($urandom_range(0, 99) < 6), lv, ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 75), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 8));
    end

    step("ar_load4", 1, 8'd4, 0, 0, 0, 0);
    step("ar_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    load = 0; start = 0; en = 0; clr_uf = 0;
    #1 rb = 1'b0;
    #1;
    chk("async.count", count, 0);
    chk("async.tc", tc, 0);
    chk("async.underflow", underflow, 0);
    chk("async.busy", busy, 0);
    chk("async.zero", zero, 1);
    model_reset();
    @(negedge clk);
    rb = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_en", 0, 0, 0, 1, 0, 0);
    step("post_rst_start", 0, 0, 1, 0, 0, 0);
    step("post_rst_dec", 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_downcounter.md
Name: alu_downcounter

Overview:
- Loadable 8-bit down-counter/timer for the ALU counter cluster; it is the decrementing counterpart of the free-running up-counters.
- Counts down from a programmed value on each enabled clock and flags terminal count.
- Supports optional auto-reload for periodic ticks.
- Reports a sticky underflow when it is enabled while expired.
- Sits beside the up-counters under the ALU top and shares their clock and reset.

Parameters:
WIDTH, 8, counter and load-value width
RELOAD_DEFAULT, 8'hFF, reload register value after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rb  input  1  asynchronous active-low reset
load  input  1  load load_val into count and into the reload register
load_val  input  WIDTH  value for load
start  input  1  restart from the reload register
en  input  1  decrement enable (count tick)
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode
clr_uf  input  1  clear the sticky underflow flag
count  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse (registered)
zero  output  1  count == 0 (combinational from count)
underflow  output  1  sticky underflow flag (registered)
busy  output  1  state == RUN

Behaviour:
- Reset (rb low, asynchronous): count=0, reload_reg=RELOAD_DEFAULT, state=IDLE, tc=0, underflow=0. Outputs follow: zero=1, busy=0.
- Releasing rb mid-operation always restarts from IDLE. No in-progress count survives reset.
- FSM states:
  - IDLE: after reset. en is ignored.
  - RUN: decrementing.
  - EXPIRED: one-shot reached zero; count holds 0.
- Command priority each cycle: load > start > en.
- load, any state:
  - count <= load_val and reload_reg <= load_val.
  - If load_val != 0, next state is RUN. If load_val == 0, next state is EXPIRED.
  - No tc in either case.
- start (no load), any state:
  - count <= reload_reg.
  - Next state is RUN if reload_reg != 0, else EXPIRED.
- RUN with en, count > 1: count <= count-1.
- RUN with en, count == 1: count <= 0, tc <= 1 for exactly one cycle. tc is high in the first cycle count reads 0.
- RUN with en, count == 0:
  - auto_reload=1 and reload_reg != 0: count <= reload_reg, stay in RUN.
  - Otherwise: go to EXPIRED, count stays 0.
  - auto_reload=0 therefore costs one extra en to reach EXPIRED; busy drops in that cycle.
- Periodic mode with reload R: count sequence R, R-1, ..., 0, R, ...; period is R+1 en ticks; exactly one tc per period.
- EXPIRED with en (no load/start): underflow <= 1, count stays 0, no tc.
- underflow is sticky and clears only on clr_uf or reset. If set and clr_uf occur in the same cycle, set wins.
- tc is 0 in every cycle not described above.
- auto_reload is sampled only at the count==0 decision point; changing it mid-count has no other effect.
- Arithmetic is modulo 2^WIDTH but never wraps below 0. Decrement of 0 never occurs.
- Latency: every output changes on the clock edge after the causing input, except zero, which follows count combinationally.

Test Plan:
- Reset then release, 3 cycles of en -> count=0, zero=1, busy=0, tc=0, underflow=0; reload_reg=8'hFF checked via start -> count=8'hFF, busy=1.
- load load_val=3, auto_reload=0, en held -> count 3,2,1,0; tc high only in the first count=0 cycle; next en -> EXPIRED, busy=0; further en -> underflow=1, count stays 0.
- load 2, auto_reload=1, en held 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc high 3 times, each aligned with count=0; underflow=0.
- load load_val=0 -> state EXPIRED, count=0, no tc. Then start with reload_reg=0 -> remains EXPIRED. Then en -> underflow=1. Then clr_uf and en in the same cycle -> underflow remains 1.
- Count at 5 with load=1 (load_val=7), start=1 and en=1 all in one cycle -> count=7, reload_reg=7. Next cycle with en only -> count=6.
- Assert rb low asynchronously mid-cycle while count=4 in RUN -> count=0, tc=0, underflow=0, busy=0 immediately, without waiting for a clk edge. After release, en has no effect until load or start.
